// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction field positions, opcodes, functs and the ID/EX record.
// Imported by the decode stage, its register file and the decode interface.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FN_HI    = 5;
    localparam int FN_LO    = 0;
    localparam int IMM16_HI = 15;
    localparam int IMM26_HI = 25;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ALU  = 6'h01;
    localparam logic [5:0] OP_ADDI = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h03;
    localparam logic [5:0] OP_SW   = 6'h04;
    localparam logic [5:0] OP_BEQ  = 6'h05;
    localparam logic [5:0] OP_BNE  = 6'h06;
    localparam logic [5:0] OP_J    = 6'h07;
    localparam logic [5:0] OP_JAL  = 6'h08;
    localparam logic [5:0] OP_JR   = 6'h09;

    localparam logic [5:0] FN_ADD = 6'h20;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    localparam logic [1:0] PCSRC_NPC    = 2'd0;
    localparam logic [1:0] PCSRC_TARGET = 2'd1;
    localparam logic [1:0] PCSRC_REG    = 2'd2;

    localparam logic [RA_W-1:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic            valid;
        logic            regWr;
        logic            memRd;
        logic            memWr;
        logic [5:0]      op;
        logic [5:0]      funct;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] npc;
    } idex_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch, hazard, write-back and ID/EX signals around the decode stage.
// master drives the stage inputs (pipeline side); slave is the decode stage itself.
interface decode_stage_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] IR;
    logic [XLEN-1:0] NPC;
    logic            ex_wr_en;
    logic            ex_is_load;
    logic [RA_W-1:0] ex_rd;
    logic            mem_wr_en;
    logic [RA_W-1:0] mem_rd;
    logic            wb_en;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            PCWr;
    logic            IRWrite;
    logic            KILL;
    logic [1:0]      PCSrc;
    logic [XLEN-1:0] TargetAddress;
    logic [XLEN-1:0] RegRs;

    logic            idex_valid;
    logic            idex_RegWr;
    logic            idex_MemRd;
    logic            idex_MemWr;
    logic [5:0]      idex_op;
    logic [5:0]      idex_funct;
    logic [RA_W-1:0] idex_rs;
    logic [RA_W-1:0] idex_rt;
    logic [RA_W-1:0] idex_rd;
    logic [XLEN-1:0] idex_A;
    logic [XLEN-1:0] idex_B;
    logic [XLEN-1:0] idex_Imm;
    logic [XLEN-1:0] idex_NPC;

    modport master (
        output IR, NPC, ex_wr_en, ex_is_load, ex_rd, mem_wr_en, mem_rd,
               wb_en, wb_rd, wb_data,
        input  PCWr, IRWrite, KILL, PCSrc, TargetAddress, RegRs,
               idex_valid, idex_RegWr, idex_MemRd, idex_MemWr, idex_op, idex_funct,
               idex_rs, idex_rt, idex_rd, idex_A, idex_B, idex_Imm, idex_NPC
    );

    modport slave (
        input  IR, NPC, ex_wr_en, ex_is_load, ex_rd, mem_wr_en, mem_rd,
               wb_en, wb_rd, wb_data,
        output PCWr, IRWrite, KILL, PCSrc, TargetAddress, RegRs,
               idex_valid, idex_RegWr, idex_MemRd, idex_MemWr, idex_op, idex_funct,
               idex_rs, idex_rt, idex_rd, idex_A, idex_B, idex_Imm, idex_NPC
    );

endinterface

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one clocked write port, R0 hardwired to 0.
// With BYPASS set, a read of the register being written this cycle returns the incoming data.
module reg_file
    import cpu_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] i_raddr1,
    input  logic [RA_W-1:0] i_raddr2,
    input  logic            i_we,
    input  logic [RA_W-1:0] i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (BYPASS && i_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (BYPASS && i_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field decode, register read, hazard stalls, early branch/jump
// resolution and the ID/EX pipeline register.
module decode_stage
    import cpu_pkg::*;
#(
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);

    logic [5:0]      w_op;
    logic [RA_W-1:0] w_rs;
    logic [RA_W-1:0] w_rt;
    logic [RA_W-1:0] w_rd;
    logic [5:0]      w_funct;
    logic [XLEN-1:0] w_imm;
    logic [25:0]     w_imm26;
    logic [XLEN-1:0] w_rsVal;
    logic [XLEN-1:0] w_rtVal;

    assign w_op    = bus.IR[OP_HI:OP_LO];
    assign w_rs    = bus.IR[RS_HI:RS_LO];
    assign w_rt    = bus.IR[RT_HI:RT_LO];
    assign w_rd    = bus.IR[RD_HI:RD_LO];
    assign w_funct = bus.IR[FN_HI:FN_LO];
    assign w_imm   = sext16(bus.IR[IMM16_HI:0]);
    assign w_imm26 = bus.IR[IMM26_HI:0];

    // Opcodes outside the known set decode to nothing, which makes them behave as NOP.
    logic w_isAlu, w_isAddi, w_isLw, w_isSw, w_isBeq, w_isBne, w_isJ, w_isJal, w_isJr;
    assign w_isAlu  = (w_op == OP_ALU);
    assign w_isAddi = (w_op == OP_ADDI);
    assign w_isLw   = (w_op == OP_LW);
    assign w_isSw   = (w_op == OP_SW);
    assign w_isBeq  = (w_op == OP_BEQ);
    assign w_isBne  = (w_op == OP_BNE);
    assign w_isJ    = (w_op == OP_J);
    assign w_isJal  = (w_op == OP_JAL);
    assign w_isJr   = (w_op == OP_JR);

    logic w_valid, w_usesRs, w_usesRt, w_isCtrl;
    assign w_valid  = w_isAlu | w_isAddi | w_isLw | w_isSw | w_isBeq | w_isBne
                    | w_isJ | w_isJal | w_isJr;
    assign w_usesRs = w_isAlu | w_isAddi | w_isLw | w_isSw | w_isBeq | w_isBne | w_isJr;
    assign w_usesRt = w_isAlu | w_isSw | w_isBeq | w_isBne;
    assign w_isCtrl = w_isBeq | w_isBne | w_isJr;

    reg_file #(.BYPASS(RF_BYPASS)) u_regFile (
        .clk      (clk),
        .reset    (reset),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .i_we     (bus.wb_en),
        .i_waddr  (bus.wb_rd),
        .i_wdata  (bus.wb_data),
        .o_rdata1 (w_rsVal),
        .o_rdata2 (w_rtVal)
    );

    logic [RA_W-1:0] w_dest;
    always_comb begin
        w_dest = '0;
        if (w_isAlu) begin
            w_dest = w_rd;
        end else if (w_isAddi || w_isLw) begin
            w_dest = w_rt;
        end else if (w_isJal) begin
            w_dest = LINK_REG;
        end
    end

    // Branches resolve here, so they must also wait for producers still in EX or MEM.
    logic w_loadUse, w_exHit, w_memHit, w_stall;
    assign w_loadUse = bus.ex_is_load && (bus.ex_rd != '0)
                     && ((w_usesRs && (w_rs == bus.ex_rd)) || (w_usesRt && (w_rt == bus.ex_rd)));
    assign w_exHit   = bus.ex_wr_en && (bus.ex_rd != '0)
                     && ((w_usesRs && (w_rs == bus.ex_rd)) || (w_usesRt && (w_rt == bus.ex_rd)));
    assign w_memHit  = bus.mem_wr_en && (bus.mem_rd != '0)
                     && ((w_usesRs && (w_rs == bus.mem_rd)) || (w_usesRt && (w_rt == bus.mem_rd)));
    assign w_stall   = w_loadUse || (w_isCtrl && (w_exHit || w_memHit));

    logic [1:0] w_pcSrc;
    always_comb begin
        w_pcSrc = PCSRC_NPC;
        if (!w_stall) begin
            if (w_isJ || w_isJal) begin
                w_pcSrc = PCSRC_TARGET;
            end else if (w_isBeq && (w_rsVal == w_rtVal)) begin
                w_pcSrc = PCSRC_TARGET;
            end else if (w_isBne && (w_rsVal != w_rtVal)) begin
                w_pcSrc = PCSRC_TARGET;
            end else if (w_isJr) begin
                w_pcSrc = PCSRC_REG;
            end
        end
    end

    assign bus.PCSrc         = w_pcSrc;
    assign bus.KILL          = (w_pcSrc != PCSRC_NPC);
    assign bus.PCWr          = !w_stall;
    assign bus.IRWrite       = !w_stall;
    assign bus.RegRs         = w_rsVal;
    assign bus.TargetAddress = (w_isJ || w_isJal) ? {bus.NPC[31:26], w_imm26}
                                                  : (bus.NPC + w_imm);

    // Stalls and non-instructions enter ID/EX as an all-zero bubble.
    idex_t w_idexNext;
    always_comb begin
        w_idexNext = '0;
        if (!w_stall && w_valid) begin
            w_idexNext.valid = 1'b1;
            w_idexNext.regWr = (w_dest != '0);
            w_idexNext.memRd = w_isLw;
            w_idexNext.memWr = w_isSw;
            w_idexNext.op    = w_op;
            w_idexNext.funct = w_funct;
            w_idexNext.rs    = w_rs;
            w_idexNext.rt    = w_rt;
            w_idexNext.rd    = w_dest;
            w_idexNext.a     = w_rsVal;
            w_idexNext.b     = w_rtVal;
            w_idexNext.imm   = w_imm;
            w_idexNext.npc   = bus.NPC;
            if (w_isJal) begin
                w_idexNext.op    = OP_ALU;
                w_idexNext.funct = FN_ADD;
                w_idexNext.rs    = '0;
                w_idexNext.rt    = '0;
                w_idexNext.a     = bus.NPC;
                w_idexNext.b     = '0;
            end
        end
    end

    idex_t r_idex;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_idexNext;
        end
    end

    assign bus.idex_valid = r_idex.valid;
    assign bus.idex_RegWr = r_idex.regWr;
    assign bus.idex_MemRd = r_idex.memRd;
    assign bus.idex_MemWr = r_idex.memWr;
    assign bus.idex_op    = r_idex.op;
    assign bus.idex_funct = r_idex.funct;
    assign bus.idex_rs    = r_idex.rs;
    assign bus.idex_rt    = r_idex.rt;
    assign bus.idex_rd    = r_idex.rd;
    assign bus.idex_A     = r_idex.a;
    assign bus.idex_B     = r_idex.b;
    assign bus.idex_Imm   = r_idex.imm;
    assign bus.idex_NPC   = r_idex.npc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: operand read/bypass, hazards, branches, jumps, reset.
module tb_decode_stage;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    decode_stage_if bus ();

    decode_stage #(.RF_BYPASS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h01, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clearInputs();
        bus.IR         = 32'h0;
        bus.NPC        = 32'h0;
        bus.ex_wr_en   = 1'b0;
        bus.ex_is_load = 1'b0;
        bus.ex_rd      = 5'd0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_rd     = 5'd0;
        bus.wb_en      = 1'b0;
        bus.wb_rd      = 5'd0;
        bus.wb_data    = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.idex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", bus.idex_valid); end
        checks++; if (bus.idex_A !== 32'h0) begin errors++; $display("FAIL reset_A got=%h exp=0", bus.idex_A); end
        reset = 1'b0;
        #1;
        checks++; if (bus.PCWr !== 1'b1 || bus.IRWrite !== 1'b1) begin errors++; $display("FAIL reset_enables got=%0b%0b exp=11", bus.PCWr, bus.IRWrite); end
        checks++; if (bus.KILL !== 1'b0 || bus.PCSrc !== 2'd0) begin errors++; $display("FAIL reset_redirect got kill=%0b pcsrc=%0d exp 0/0", bus.KILL, bus.PCSrc); end
        tick();
    endtask

    task automatic test_addi_add();
        clearInputs();
        bus.IR = iType(6'h02, 5'd0, 5'd1, 16'd5);
        tick();
        checks++; if (bus.idex_valid !== 1'b1 || bus.idex_rd !== 5'd1 || bus.idex_RegWr !== 1'b1) begin errors++; $display("FAIL addi_dest got v=%0b rd=%0d wr=%0b exp 1/1/1", bus.idex_valid, bus.idex_rd, bus.idex_RegWr); end
        checks++; if (bus.idex_Imm !== 32'd5 || bus.idex_A !== 32'd0) begin errors++; $display("FAIL addi_ops got imm=%h A=%h exp 5/0", bus.idex_Imm, bus.idex_A); end
        bus.IR = rType(5'd1, 5'd1, 5'd2, 6'h20);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
        tick();
        checks++; if (bus.idex_A !== 32'd5 || bus.idex_B !== 32'd5) begin errors++; $display("FAIL add_bypass got A=%h B=%h exp 5/5", bus.idex_A, bus.idex_B); end
        checks++; if (bus.idex_rd !== 5'd2) begin errors++; $display("FAIL add_rd got=%0d exp=2", bus.idex_rd); end
        bus.wb_en = 1'b0;
        tick();
        checks++; if (bus.idex_A !== 32'd5 || bus.idex_B !== 32'd5) begin errors++; $display("FAIL add_rfread got A=%h B=%h exp 5/5", bus.idex_A, bus.idex_B); end
    endtask

    task automatic test_load_use();
        clearInputs();
        bus.IR = rType(5'd3, 5'd0, 5'd4, 6'h20);
        bus.ex_is_load = 1'b1; bus.ex_wr_en = 1'b1; bus.ex_rd = 5'd3;
        #1;
        checks++; if (bus.PCWr !== 1'b0 || bus.IRWrite !== 1'b0 || bus.KILL !== 1'b0) begin errors++; $display("FAIL lu_stall got pcwr=%0b irw=%0b kill=%0b exp 0/0/0", bus.PCWr, bus.IRWrite, bus.KILL); end
        tick();
        checks++; if (bus.idex_valid !== 1'b0 || bus.idex_RegWr !== 1'b0) begin errors++; $display("FAIL lu_bubble got v=%0b wr=%0b exp 0/0", bus.idex_valid, bus.idex_RegWr); end
        bus.ex_is_load = 1'b0; bus.ex_wr_en = 1'b0; bus.ex_rd = 5'd0;
        #1;
        checks++; if (bus.PCWr !== 1'b1) begin errors++; $display("FAIL lu_release got=%0b exp=1", bus.PCWr); end
        tick();
        checks++; if (bus.idex_valid !== 1'b1 || bus.idex_rd !== 5'd4) begin errors++; $display("FAIL lu_issue got v=%0b rd=%0d exp 1/4", bus.idex_valid, bus.idex_rd); end
        bus.IR = rType(5'd0, 5'd3, 5'd4, 6'h20);
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd3;
        #1;
        checks++; if (bus.PCWr !== 1'b0) begin errors++; $display("FAIL lu_rt got=%0b exp=0", bus.PCWr); end
        bus.IR = rType(5'd0, 5'd0, 5'd4, 6'h20);
        bus.ex_rd = 5'd0;
        #1;
        checks++; if (bus.PCWr !== 1'b1) begin errors++; $display("FAIL lu_r0 got=%0b exp=1", bus.PCWr); end
        tick();
    endtask

    task automatic test_branch();
        clearInputs();
        bus.NPC = 32'd10;
        bus.IR = iType(6'h05, 5'd1, 5'd1, 16'd4);
        #1;
        checks++; if (bus.PCSrc !== 2'd1 || bus.TargetAddress !== 32'd14 || bus.KILL !== 1'b1) begin errors++; $display("FAIL beq_taken got pcsrc=%0d tgt=%h kill=%0b exp 1/e/1", bus.PCSrc, bus.TargetAddress, bus.KILL); end
        checks++; if (bus.PCWr !== 1'b1 || bus.IRWrite !== 1'b1) begin errors++; $display("FAIL beq_enables got=%0b%0b exp=11", bus.PCWr, bus.IRWrite); end
        bus.IR = iType(6'h05, 5'd1, 5'd1, 16'hFFFC);
        #1;
        checks++; if (bus.TargetAddress !== 32'd6) begin errors++; $display("FAIL beq_negtgt got=%h exp=6", bus.TargetAddress); end
        tick();
        checks++; if (bus.idex_Imm !== 32'hFFFF_FFFC || bus.idex_RegWr !== 1'b0 || bus.idex_NPC !== 32'd10) begin errors++; $display("FAIL beq_idex got imm=%h wr=%0b npc=%h exp fffffffc/0/a", bus.idex_Imm, bus.idex_RegWr, bus.idex_NPC); end
        bus.IR = iType(6'h06, 5'd1, 5'd1, 16'd4);
        #1;
        checks++; if (bus.PCSrc !== 2'd0 || bus.KILL !== 1'b0) begin errors++; $display("FAIL bne_equal got pcsrc=%0d kill=%0b exp 0/0", bus.PCSrc, bus.KILL); end
        bus.IR = iType(6'h06, 5'd1, 5'd0, 16'd4);
        #1;
        checks++; if (bus.PCSrc !== 2'd1) begin errors++; $display("FAIL bne_taken got=%0d exp=1", bus.PCSrc); end
        bus.IR = iType(6'h05, 5'd1, 5'd0, 16'd4);
        #1;
        checks++; if (bus.PCSrc !== 2'd0) begin errors++; $display("FAIL beq_nottaken got=%0d exp=0", bus.PCSrc); end
        bus.IR = iType(6'h05, 5'd1, 5'd1, 16'd4);
        bus.mem_wr_en = 1'b1; bus.mem_rd = 5'd1;
        #1;
        checks++; if (bus.PCSrc !== 2'd0 || bus.PCWr !== 1'b0 || bus.KILL !== 1'b0) begin errors++; $display("FAIL beq_priority got pcsrc=%0d pcwr=%0b kill=%0b exp 0/0/0", bus.PCSrc, bus.PCWr, bus.KILL); end
        tick();
    endtask

    task automatic test_jr();
        clearInputs();
        bus.IR = iType(6'h09, 5'd5, 5'd0, 16'd0);
        bus.ex_wr_en = 1'b1; bus.ex_rd = 5'd5;
        #1;
        checks++; if (bus.PCWr !== 1'b0 || bus.PCSrc !== 2'd0 || bus.KILL !== 1'b0) begin errors++; $display("FAIL jr_exstall got pcwr=%0b pcsrc=%0d kill=%0b exp 0/0/0", bus.PCWr, bus.PCSrc, bus.KILL); end
        tick();
        checks++; if (bus.idex_valid !== 1'b0) begin errors++; $display("FAIL jr_bubble got=%0b exp=0", bus.idex_valid); end
        bus.ex_wr_en = 1'b0; bus.ex_rd = 5'd0;
        bus.mem_wr_en = 1'b1; bus.mem_rd = 5'd5;
        #1;
        checks++; if (bus.PCWr !== 1'b0 || bus.IRWrite !== 1'b0) begin errors++; $display("FAIL jr_memstall got=%0b%0b exp=00", bus.PCWr, bus.IRWrite); end
        bus.mem_wr_en = 1'b0; bus.mem_rd = 5'd0;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h40;
        #1;
        checks++; if (bus.PCSrc !== 2'd2 || bus.RegRs !== 32'h40 || bus.KILL !== 1'b1) begin errors++; $display("FAIL jr_redirect got pcsrc=%0d rs=%h kill=%0b exp 2/40/1", bus.PCSrc, bus.RegRs, bus.KILL); end
        tick();
    endtask

    task automatic test_jal_r0();
        clearInputs();
        bus.NPC = 32'h0400_0007;
        bus.IR = {6'h08, 26'h100};
        #1;
        checks++; if (bus.TargetAddress !== 32'h0400_0100 || bus.PCSrc !== 2'd1) begin errors++; $display("FAIL jal_target got tgt=%h pcsrc=%0d exp 04000100/1", bus.TargetAddress, bus.PCSrc); end
        tick();
        checks++; if (bus.idex_rd !== 5'd31 || bus.idex_A !== 32'h0400_0007 || bus.idex_B !== 32'h0) begin errors++; $display("FAIL jal_link got rd=%0d A=%h B=%h exp 31/04000007/0", bus.idex_rd, bus.idex_A, bus.idex_B); end
        checks++; if (bus.idex_op !== 6'h01 || bus.idex_funct !== 6'h20 || bus.idex_RegWr !== 1'b1) begin errors++; $display("FAIL jal_op got op=%h fn=%h wr=%0b exp 01/20/1", bus.idex_op, bus.idex_funct, bus.idex_RegWr); end
        bus.IR = iType(6'h09, 5'd0, 5'd0, 16'd0);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.RegRs !== 32'h0) begin errors++; $display("FAIL r0_bypass got=%h exp=0", bus.RegRs); end
        tick();
        bus.wb_en = 1'b0;
        #1;
        checks++; if (bus.RegRs !== 32'h0) begin errors++; $display("FAIL r0_write got=%h exp=0", bus.RegRs); end
        tick();
    endtask

    task automatic test_misc_ops();
        clearInputs();
        bus.IR = {6'h3F, 26'h0};
        #1;
        checks++; if (bus.PCSrc !== 2'd0 || bus.PCWr !== 1'b1) begin errors++; $display("FAIL unk_pc got pcsrc=%0d pcwr=%0b exp 0/1", bus.PCSrc, bus.PCWr); end
        tick();
        checks++; if (bus.idex_valid !== 1'b0 || bus.idex_RegWr !== 1'b0) begin errors++; $display("FAIL unk_bubble got v=%0b wr=%0b exp 0/0", bus.idex_valid, bus.idex_RegWr); end
        bus.IR = iType(6'h03, 5'd1, 5'd6, 16'd8);
        tick();
        checks++; if (bus.idex_MemRd !== 1'b1 || bus.idex_rd !== 5'd6 || bus.idex_A !== 32'd5) begin errors++; $display("FAIL lw_idex got mrd=%0b rd=%0d A=%h exp 1/6/5", bus.idex_MemRd, bus.idex_rd, bus.idex_A); end
        bus.IR = iType(6'h04, 5'd1, 5'd6, 16'd8);
        tick();
        checks++; if (bus.idex_MemWr !== 1'b1 || bus.idex_RegWr !== 1'b0 || bus.idex_rd !== 5'd0) begin errors++; $display("FAIL sw_idex got mwr=%0b wr=%0b rd=%0d exp 1/0/0", bus.idex_MemWr, bus.idex_RegWr, bus.idex_rd); end
    endtask

    task automatic test_reset_mid_stall();
        bus.IR = rType(5'd3, 5'd0, 5'd4, 6'h20);
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd3;
        #1;
        checks++; if (bus.PCWr !== 1'b0) begin errors++; $display("FAIL rms_prestall got=%0b exp=0", bus.PCWr); end
        reset = 1'b1;
        #1;
        checks++; if (bus.idex_valid !== 1'b0 || bus.idex_A !== 32'h0 || bus.idex_MemWr !== 1'b0) begin errors++; $display("FAIL rms_clear got v=%0b A=%h mwr=%0b exp 0/0/0", bus.idex_valid, bus.idex_A, bus.idex_MemWr); end
        clearInputs();
        #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.PCWr !== 1'b1 || bus.IRWrite !== 1'b1 || bus.KILL !== 1'b0 || bus.PCSrc !== 2'd0) begin errors++; $display("FAIL rms_fetch got pcwr=%0b irw=%0b kill=%0b pcsrc=%0d exp 1/1/0/0", bus.PCWr, bus.IRWrite, bus.KILL, bus.PCSrc); end
        bus.IR = iType(6'h09, 5'd1, 5'd0, 16'd0);
        #1;
        checks++; if (bus.RegRs !== 32'h0) begin errors++; $display("FAIL rms_regclear got=%h exp=0", bus.RegRs); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        clearInputs();
        test_reset();
        test_addi_add();
        test_load_use();
        test_branch();
        test_jr();
        test_jal_r0();
        test_misc_ops();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter RF_BYPASS, default 1, meaning: a same-cycle write-back to a read register returns wb_data.
REQ-002 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports IR / NPC  in  32 / 32  instruction and PC+1 latched by fetch.
REQ-005 SHALL have ports ex_wr_en, ex_is_load  in  1 each; ex_rd  in  5  EX-stage producer info.
REQ-006 SHALL have ports mem_wr_en  in  1; mem_rd  in  5  MEM-stage producer info.
REQ-007 SHALL have ports wb_en  in  1; wb_rd  in  5; wb_data  in  32  register write-back.
REQ-008 SHALL have ports PCWr, IRWrite, KILL  out  1 each  fetch enables and squash.
REQ-009 SHALL have ports PCSrc  out  2 (0 = PC+1, 1 = target, 2 = Reg[Rs]); TargetAddress, RegRs  out  32.
REQ-010 SHALL have ID/EX register outputs: idex_valid, idex_RegWr, idex_MemRd, idex_MemWr (1 each); idex_op (6); idex_funct (6); idex_rs, idex_rt, idex_rd (5 each); idex_A, idex_B, idex_Imm, idex_NPC (32 each).

Function
REQ-011 SHALL decode the fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm16[15:0] and imm26[25:0].
REQ-012 SHALL support the opcodes NOP=00, ALU=01, ADDI=02, LW=03, SW=04, BEQ=05, BNE=06, J=07, JAL=08 and JR=09; any other opcode SHALL be treated as NOP.
REQ-013 SHALL implement a 32x32 register file with R0 reading 0 and writes to R0 ignored; writes occur on the clock edge when wb_en=1.
REQ-014 SHALL return wb_data on a read when RF_BYPASS=1, wb_en=1, wb_rd equals the read index and the index is nonzero.
REQ-015 SHALL compute the destination: rd for ALU; rt for ADDI and LW; 31 for JAL; 0 otherwise, with RegWr = (destination != 0).
REQ-016 SHALL sign-extend imm16 to idex_Imm and compute the branch target as NPC + sext(imm16) (32-bit, wrapping).
REQ-017 SHALL compute the jump target as {NPC[31:26], imm26}.
REQ-018 SHALL assert a load-use stall when ex_is_load=1, ex_rd != 0 and ex_rd matches a source register the instruction reads.
REQ-019 SHALL assert a control stall when the instruction is BEQ, BNE or JR and a source it reads matches a nonzero ex_rd with ex_wr_en=1, or a nonzero mem_rd with mem_wr_en=1.
REQ-020 SHALL, during a stall, drive PCWr=0, IRWrite=0, KILL=0 and PCSrc=0, and load a bubble into ID/EX (idex_valid and all control bits 0).
REQ-021 SHALL, when not stalled, select PCSrc=1 for J, JAL, BEQ with equal operands and BNE with unequal operands; PCSrc=2 for JR; and PCSrc=0 otherwise.
REQ-022 SHALL drive KILL=1 exactly when PCSrc != 0, with PCWr=1 and IRWrite=1 in that cycle.
REQ-023 SHALL drive TargetAddress and RegRs continuously; RegRs equals the bypassed rs read value.
REQ-024 SHALL have JAL write NPC to R31 through the pipeline: idex_A=NPC, idex_B=0, idex_op=ALU, idex_funct=ADD.
REQ-025 SHALL pass the bypassed rs and rt read values to idex_A and idex_B, and idex_NPC=NPC, one cycle after decode.
REQ-026 SHALL set idex_valid=0 for an IR of 32'h0 or an unknown opcode.
REQ-027 SHALL give stall priority over redirect; the redirect is evaluated again once the stall clears.

Reset
REQ-028 SHALL, while reset=1, clear all ID/EX outputs and all 32 registers to 0.
REQ-029 SHALL drive PCWr=1, IRWrite=1, KILL=0 and PCSrc=0 for IR=0 after reset; behaviour SHALL be identical for a reset asserted mid-stall.

Structure
REQ-030 SHALL place the opcode and funct localparams, the NOP word and the field bit positions in shared package cpu_pkg.
REQ-031 SHALL implement the register file as sub-module reg_file (two read ports, one write port, bypass).

Verification
REQ-032 SHALL cover: ADDI R1,R0,5, then wb R1=5 -> ADD R2,R1,R1 gives idex_A=idex_B=5 and idex_rd=2.
REQ-033 SHALL cover: LW R3 in EX (ex_is_load=1, ex_rd=3), then ADD R4,R3,R0 -> one cycle with PCWr=IRWrite=0 and idex_valid=0, then normal issue.
REQ-034 SHALL cover: BEQ R1,R1,+4 with NPC=10 and no hazard -> PCSrc=1, TargetAddress=14, KILL=1.
REQ-035 SHALL cover: BNE with equal operands -> PCSrc=0 and KILL=0.
REQ-036 SHALL cover: JR R5 with ex_wr_en=1 and ex_rd=5 -> stall; when mem_rd=5 -> stall; when in WB with wb_data=0x40 -> PCSrc=2 and RegRs=0x40.
REQ-037 SHALL cover: JAL imm26=0x100 with NPC=0x0400_0007 -> TargetAddress=0x0400_0100, idex_rd=31 and idex_A=0x0400_0007; writing R0 leaves R0 reading 0.
